alu_pipe: RTL and testbench

- Parametrised, pipelined integer ALU; successor to the single-function combinational ALU slices (e.g. the AND slice).
- Performs ten operations on two WIDTH-bit operands, selected per transaction by an opcode.
- Results and condition flags are registered behind a 2-stage valid/ready pipeline with full-throughput backpressure and a synchronous flush.
- Sits between the decode/operand-read stage and the writeback stage of the datapath.

---
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 tb/tb_alu_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Two-stage pipelined integer ALU with valid/ready handshaking,
//             full-throughput backpressure and a synchronous flush.
//             Stage 1 registers the operands; stage 2 registers the result
//             and condition flags computed from the stage-1 registers.
//  Ports    : clk, rst (async, active-high), flush (sync clear)
//             in_valid/in_ready, op, rs1, rs2       - operand side
//             out_valid/out_ready, rd, flag_z/c/v/ill - result side
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_ill
);

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_XOR  = 4'd2;
    localparam logic [3:0] c_OP_ADD  = 4'd3;
    localparam logic [3:0] c_OP_SUB  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;

    // Stage-1 (operand) registers
    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_rs1;
    logic [WIDTH-1:0] r_s1_rs2;

    // Stage-2 (result) registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_rd;
    logic             r_s2_z;
    logic             r_s2_c;
    logic             r_s2_v;
    logic             r_s2_ill;

    // Pipeline control: a stage may load when it is empty or its contents
    // are leaving this cycle.
    logic w_adv1;
    logic w_adv2;

    assign w_adv2   = ~r_s2_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    // Datapath
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [WIDTH-1:0] w_rd;
    logic             w_c;
    logic             w_v;
    logic             w_ill;
    logic             w_z;

    // One extra bit on each side exposes carry-out / borrow directly.
    assign w_sum   = {1'b0, r_s1_rs1} + {1'b0, r_s1_rs2};
    assign w_diff  = {1'b0, r_s1_rs1} - {1'b0, r_s1_rs2};
    assign w_shamt = r_s1_rs2[SHW-1:0];
    assign w_lt_s  = $signed(r_s1_rs1) < $signed(r_s1_rs2);
    assign w_lt_u  = r_s1_rs1 < r_s1_rs2;

    always_comb begin
        w_rd  = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (r_s1_op)
            c_OP_AND:  w_rd = r_s1_rs1 & r_s1_rs2;
            c_OP_OR:   w_rd = r_s1_rs1 | r_s1_rs2;
            c_OP_XOR:  w_rd = r_s1_rs1 ^ r_s1_rs2;
            c_OP_ADD: begin
                w_rd = w_sum[WIDTH-1:0];
                w_c  = w_sum[WIDTH];
                w_v  = (r_s1_rs1[WIDTH-1] == r_s1_rs2[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_s1_rs1[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_rd = w_diff[WIDTH-1:0];
                w_c  = w_diff[WIDTH];   // borrow, i.e. rs1 < rs2 unsigned
                w_v  = (r_s1_rs1[WIDTH-1] != r_s1_rs2[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != r_s1_rs1[WIDTH-1]);
            end
            c_OP_SLL:  w_rd = r_s1_rs1 << w_shamt;
            c_OP_SRL:  w_rd = r_s1_rs1 >> w_shamt;
            c_OP_SRA:  w_rd = $signed(r_s1_rs1) >>> w_shamt;
            c_OP_SLT:  w_rd = {{(WIDTH-1){1'b0}}, w_lt_s};
            c_OP_SLTU: w_rd = {{(WIDTH-1){1'b0}}, w_lt_u};
            default:   w_ill = 1'b1;  // result stays zero
        endcase
    end

    assign w_z = (w_rd == '0);

    // Stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_adv1) begin
                r_s1_valid <= in_valid;
            end
            // Data registers are don't-care while invalid, so they load on
            // every advance regardless of flush.
            if (w_adv1) begin
                r_s1_op  <= op;
                r_s1_rs1 <= rs1;
                r_s1_rs2 <= rs2;
            end
        end
    end

    // Stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_rd    <= '0;
            r_s2_z     <= 1'b0;
            r_s2_c     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s2_ill   <= 1'b0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_adv2) begin
                r_s2_rd  <= w_rd;
                r_s2_z   <= w_z;
                r_s2_c   <= w_c;
                r_s2_v   <= w_v;
                r_s2_ill <= w_ill;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign rd        = r_s2_rd;
    assign flag_z    = r_s2_z;
    assign flag_c    = r_s2_c;
    assign flag_v    = r_s2_v;
    assign flag_ill  = r_s2_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Directed self-checking bench for alu_pipe at WIDTH=32 and
//             WIDTH=8: opcode vectors, flags, latency, backpressure stall,
//             flush and asynchronous reset in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam logic [3:0] c_AND  = 4'd0;
    localparam logic [3:0] c_OR   = 4'd1;
    localparam logic [3:0] c_XOR  = 4'd2;
    localparam logic [3:0] c_ADD  = 4'd3;
    localparam logic [3:0] c_SUB  = 4'd4;
    localparam logic [3:0] c_SLL  = 4'd5;
    localparam logic [3:0] c_SRL  = 4'd6;
    localparam logic [3:0] c_SRA  = 4'd7;
    localparam logic [3:0] c_SLT  = 4'd8;
    localparam logic [3:0] c_SLTU = 4'd9;

    logic        clk = 1'b0;
    logic        rst;

    // WIDTH=32 instance
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] rs1, rs2, rd;
    logic        flag_z, flag_c, flag_v, flag_ill;

    // WIDTH=8 instance
    logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0]  op8;
    logic [7:0]  rs1_8, rs2_8, rd8;
    logic        z8, c8, v8, ill8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .flag_ill(flag_ill)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .rs1(rs1_8), .rs2(rs2_8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .rd(rd8), .flag_z(z8), .flag_c(c8), .flag_v(v8),
        .flag_ill(ill8)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction through the 32-bit pipe with out_ready high.
    // Flags are compared as {z, c, v, ill}.
    task automatic run32(input string tag, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, input logic [3:0] exp_f);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_rd"}, 64'(rd), 64'(exp_rd));
        check({tag, "_flags"}, 64'({flag_z, flag_c, flag_v, flag_ill}),
              64'(exp_f));
    endtask

    task automatic run8(input string tag, input logic [3:0] o,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_rd, input logic [3:0] exp_f);
        op8 = o; rs1_8 = a; rs2_8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready8), 64'd1);
        step();
        in_valid8 = 1'b0;
        step();
        check({tag, "_valid"}, 64'(out_valid8), 64'd1);
        check({tag, "_rd"}, 64'(rd8), 64'(exp_rd));
        check({tag, "_flags"}, 64'({z8, c8, v8, ill8}), 64'(exp_f));
    endtask

    initial begin
        logic [31:0] exp_q [6];
        int sent;
        int recv;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rs1 = '0; rs2 = '0;
        flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        op8 = '0; rs1_8 = '0; rs2_8 = '0;

        // ---- reset state ----
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_flags", 64'({flag_z, flag_c, flag_v, flag_ill}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // ---- opcode / flag vectors ----
        run32("add_wrap",   c_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100);
        run32("add_ovf",    c_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010);
        run32("sub_borrow", c_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0100);
        run32("sub_ovf",    c_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010);
        run32("sra_31",     c_SRA,  32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 4'b0000);
        run32("srl_31",     c_SRL,  32'h80000000, 32'h0000003F, 32'h00000001, 4'b0000);
        run32("sll_0",      c_SLL,  32'h00000001, 32'h00000000, 32'h00000001, 4'b0000);
        run32("sll_5",      c_SLL,  32'h00000001, 32'h00000025, 32'h00000020, 4'b0000);
        run32("slt",        c_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
        run32("sltu",       c_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000);
        run32("or",         c_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000);
        run32("xor",        c_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b0000);
        run32("illegal12",  4'd12,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b1001);
        run32("and",        c_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000);
        step();

        // ---- back-to-back stream with a 3-cycle output stall ----
        for (int i = 0; i < 6; i++) exp_q[i] = 32'(i + 1) + 32'h100;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid  = (sent < 6);
            op        = c_ADD;
            rs1       = 32'(sent + 1);
            rs2       = 32'h100;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            check("stream_in_ready", 64'(in_ready),
                  (c >= 3 && c <= 5) ? 64'd0 : 64'd1);
            if (out_valid && recv < 6) begin
                check("stream_rd", 64'(rd), 64'(exp_q[recv]));
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_recv_count", 64'(recv), 64'd6);
        check("stream_drained", 64'(out_valid), 64'd0);

        // ---- flush with two transactions in flight ----
        out_ready = 1'b0;
        op = c_XOR; rs1 = 32'h1; rs2 = 32'h2; in_valid = 1'b1;
        step();
        rs1 = 32'h3;
        step();
        check("flush_pre_valid", 64'(out_valid), 64'd1);
        check("flush_pre_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", 64'(out_valid), 64'd0);
            step();
        end
        // flush wins over a simultaneous input handshake
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_drop_in", 64'(out_valid), 64'd0);
            step();
        end

        // ---- asynchronous reset during a stall ----
        out_ready = 1'b0;
        op = c_OR; rs1 = 32'h55; rs2 = 32'h0A; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("rst_mid_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_rd", 64'(rd), 64'd0);
        check("rst_mid_flags", 64'({flag_z, flag_c, flag_v, flag_ill}), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_mid_after", 64'(out_valid), 64'd0);

        // ---- WIDTH=8 instance ----
        run8("w8_add_wrap", c_ADD,  8'hFF, 8'h01, 8'h00, 4'b1100);
        run8("w8_add_ovf",  c_ADD,  8'h7F, 8'h01, 8'h80, 4'b0010);
        run8("w8_slt",      c_SLT,  8'hFF, 8'h01, 8'h01, 4'b0000);
        run8("w8_sltu",     c_SLTU, 8'hFF, 8'h01, 8'h00, 4'b1000);
        run8("w8_sra_7",    c_SRA,  8'h80, 8'h0F, 8'hFF, 4'b0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
